// File: rtl/reg_universal.sv
`default_nettype none
// ============================================================================
// Module  : reg_universal
// Purpose : Multi-mode register (load/clear/inc/dec/negate) with a serial
//           multi-bit shifter driven by a START/BUSY/DONE handshake.
//           All state updates on the falling clock edge.
// Revision: 1.0 - initial release
// ============================================================================
module reg_universal #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [2:0]         mode_i,
  input  logic [WIDTH-1:0]   d_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               sin_i,
  output logic [WIDTH-1:0]   q_o,
  output logic               co_o,
  output logic               z_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_CLR  = 3'b010;
  localparam logic [2:0] M_INC  = 3'b011;
  localparam logic [2:0] M_DEC  = 3'b100;
  localparam logic [2:0] M_NEG  = 3'b101;
  localparam logic [2:0] M_SHL  = 3'b110;
  localparam logic [2:0] M_SHR  = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 co_q, co_d;
  logic                 done_q, done_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 dir_q, dir_d;   // 1 = shift right

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      co_q    <= co_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    co_d    = co_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          case (mode_i)
            M_HOLD: done_d = 1'b1;
            M_LOAD: begin q_d = d_i; co_d = 1'b0; done_d = 1'b1; end
            M_CLR:  begin q_d = '0;  co_d = 1'b0; done_d = 1'b1; end
            M_INC: begin
              {co_d, q_d} = {1'b0, q_q} + (WIDTH+1)'(1);
              done_d      = 1'b1;
            end
            M_DEC: begin
              // Borrow lands in the extra top bit only when wrapping from zero.
              {co_d, q_d} = {1'b0, q_q} - (WIDTH+1)'(1);
              done_d      = 1'b1;
            end
            M_NEG: begin
              q_d    = ~q_q + WIDTH'(1);
              co_d   = |q_q;
              done_d = 1'b1;
            end
            M_SHL, M_SHR: begin
              if (shamt_i == '0) begin
                done_d = 1'b1;
              end else begin
                cnt_d   = shamt_i;
                dir_d   = (mode_i == M_SHR);
                state_d = S_SHIFT;
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        if (dir_q) begin
          q_d  = {sin_i, q_q[WIDTH-1:1]};
          co_d = q_q[0];
        end else begin
          q_d  = {q_q[WIDTH-2:0], sin_i};
          co_d = q_q[WIDTH-1];
        end
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign q_o    = q_q;
  assign co_o   = co_q;
  assign z_o    = (q_q == '0);
  assign busy_o = (state_q == S_SHIFT);
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_universal.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_universal
// Purpose : Self-checking bench for reg_universal: directed scenarios plus
//           randomized operations compared against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_universal;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, CLR = 3'd2, INC = 3'd3;
  localparam logic [2:0] DEC  = 3'd4, NEG  = 3'd5, SHL = 3'd6, SHR = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [31:0] d_in = '0;
  logic [4:0]  shamt = '0;
  logic        sin = 1'b0;
  logic [31:0] q_o;
  logic        co_o, z_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  reg_universal #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .d_i(d_in), .shamt_i(shamt), .sin_i(sin),
    .q_o(q_o), .co_o(co_o), .z_o(z_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining shift count, direction, and register value.
  logic [31:0] m_q = '0;
  logic        m_co = 1'b0, m_done = 1'b0, m_right = 1'b0;
  int          m_left = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = '0; m_co = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (m_right) begin
          m_co = m_q[0];
          m_q  = (m_q >> 1) | ({31'd0, sin} << 31);
        end else begin
          m_co = m_q[31];
          m_q  = (m_q << 1) | {31'd0, sin};
        end
        m_left = m_left - 1;
        if (m_left == 0) m_done = 1'b1;
      end else if (start) begin
        m_done = 1'b1;
        case (mode)
          LOAD: begin m_q = d_in; m_co = 1'b0; end
          CLR:  begin m_q = 0;    m_co = 1'b0; end
          INC:  begin m_co = (m_q == 32'hFFFF_FFFF); m_q = m_q + 1; end
          DEC:  begin m_co = (m_q == 0); m_q = m_q - 1; end
          NEG:  begin m_co = (m_q != 0); m_q = 0 - m_q; end
          SHL, SHR: if (shamt != 0) begin
            m_left = int'(shamt); m_right = (mode == SHR); m_done = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n)
      chk("cycle_cmp", {28'd0, q_o, co_o, z_o, busy_o, done_o},
          {28'd0, m_q, m_co, (m_q == 0), (m_left != 0), m_done});
  end

  task automatic op(input logic [2:0] m, input logic [31:0] d, input logic [4:0] sh,
                    input logic s, input bit rnd, output int n);
    @(posedge clk); #1;
    start = 1'b1; mode = m; d_in = d; shamt = sh; sin = s;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy_o && n < 200) begin
      if (rnd) begin
        sin = 1'($urandom); start = ($urandom_range(0, 3) == 0);
        mode = 3'($urandom); d_in = $urandom; shamt = 5'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("busy_timeout", {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    int n;
    #2;
    chk("reset_state", {28'd0, q_o, co_o, busy_o, done_o, z_o}, {28'd0, 32'd0, 4'b0001});
    #5 rst_n = 1'b1;

    // Wrap on increment
    op(LOAD, 32'hFFFF_FFFF, 0, 0, 0, n);
    op(INC, 0, 0, 0, 0, n);
    chk("inc_wrap", {29'd0, q_o, co_o, z_o, done_o}, {29'd0, 32'd0, 3'b111});
    @(posedge clk); #1;
    chk("inc_done_clear", {63'd0, done_o}, 64'd0);

    op(LOAD, 0, 0, 0, 0, n);
    op(DEC, 0, 0, 0, 0, n);
    chk("dec_wrap", {31'd0, q_o, co_o}, {31'd0, 32'hFFFF_FFFF, 1'b1});
    op(LOAD, 5, 0, 0, 0, n);
    op(NEG, 0, 0, 0, 0, n);
    chk("neg5", {31'd0, q_o, co_o}, {31'd0, 32'hFFFF_FFFB, 1'b1});
    op(LOAD, 0, 0, 0, 0, n);
    op(NEG, 0, 0, 0, 0, n);
    chk("neg0", {31'd0, q_o, co_o}, {31'd0, 32'h0, 1'b0});
    op(LOAD, 32'h8000_0000, 0, 0, 0, n);
    op(NEG, 0, 0, 0, 0, n);
    chk("neg_min", {31'd0, q_o, co_o}, {31'd0, 32'h8000_0000, 1'b1});

    // Shifts
    op(LOAD, 32'h8000_0001, 0, 0, 0, n);
    op(SHL, 0, 4, 0, 0, n);
    chk("shl4", {31'd0, q_o, co_o}, {31'd0, 32'h0000_0010, 1'b0});
    chk("shl4_busy_cycles", 64'(n), 64'd4);
    op(LOAD, 32'h8000_0001, 0, 0, 0, n);
    op(SHL, 0, 1, 0, 0, n);
    chk("shl1", {31'd0, q_o, co_o}, {31'd0, 32'h0000_0002, 1'b1});
    op(LOAD, 32'h0000_0008, 0, 0, 0, n);
    op(SHR, 0, 3, 1, 0, n);
    chk("shr3", {30'd0, q_o, co_o, done_o}, {30'd0, 32'hE000_0001, 2'b01});
    chk("shr3_latency", 64'(n), 64'd3);

    // START during a shift is ignored
    op(LOAD, 32'h0000_00FF, 0, 0, 0, n);
    @(posedge clk); #1;
    start = 1'b1; mode = SHL; shamt = 8; sin = 1'b0;
    @(posedge clk); #1;
    mode = LOAD; d_in = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("shl8_ignore_start", {31'd0, q_o, co_o}, {31'd0, 32'h0000_FF00, 1'b0});

    op(SHR, 0, 0, 1, 0, n);
    chk("shamt0", {30'd0, q_o, busy_o, done_o}, {30'd0, 32'h0000_FF00, 2'b01});
    chk("shamt0_no_busy", 64'(n), 64'd0);

    // Asynchronous reset in the middle of a shift
    op(LOAD, 32'h1234_5678, 0, 0, 0, n);
    @(posedge clk); #1;
    start = 1'b1; mode = SHR; shamt = 10; sin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {30'd0, q_o, busy_o, done_o}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    op(LOAD, 7, 0, 0, 0, n);
    op(INC, 0, 0, 0, 0, n);
    chk("post_reset_inc", {31'd0, q_o, co_o}, {31'd0, 32'd8, 1'b0});

    // Randomized operations; the per-cycle compare does the checking
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  rm;
      logic [31:0] rd;
      rm = 3'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 9) == 0) rd = 0;
      op(rm, rd, 5'($urandom_range(0, 40) > 31 ? 0 : $urandom_range(0, 31)),
         1'($urandom), 1, n);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
